// File: rtl/clock_ctrl_pkg.sv
// Shared types, digit indices and BCD step helpers for the clock sequencing controller.
// The helpers say which strobes one field needs for a "+1"; the top decides when to apply them.
package clock_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_e;

    localparam int SEC_LO = 0;
    localparam int SEC_HI = 1;
    localparam int MIN_LO = 2;
    localparam int MIN_HI = 3;
    localparam int HR_LO  = 4;
    localparam int HR_HI  = 5;

    localparam logic [3:0] UNIT_MAX   = 4'd9;
    localparam logic [3:0] TENS60_MAX = 4'd5;

    // Same field order as the digits bus, most significant digit first.
    typedef struct packed {
        logic [3:0] hr_hi;
        logic [3:0] hr_lo;
        logic [3:0] min_hi;
        logic [3:0] min_lo;
        logic [3:0] sec_hi;
        logic [3:0] sec_lo;
    } time_t;

    // Strobes for one two-digit field: bit0 = units, bit1 = tens.
    typedef struct packed {
        logic [1:0] inc;
        logic [1:0] clr_n;
    } field_t;

    localparam field_t FIELD_IDLE = '{inc: 2'b00, clr_n: 2'b11};

    // Units counters wrap 9 -> 0 on their own, so only the mod-6 tens digit needs a clear.
    function automatic field_t sixty_step(input logic [3:0] hi, input logic [3:0] lo);
        field_t f;
        f = FIELD_IDLE;
        f.inc[0] = 1'b1;
        if (lo == UNIT_MAX) begin
            if (hi < TENS60_MAX) begin
                f.inc[1] = 1'b1;
            end else begin
                f.clr_n[1] = 1'b0;
            end
        end
        return f;
    endfunction

    function automatic logic sixty_wraps(input logic [3:0] hi, input logic [3:0] lo);
        return (lo == UNIT_MAX) && (hi >= TENS60_MAX);
    endfunction

    function automatic field_t hour_step(input logic [3:0] hi, input logic [3:0] lo,
                                         input logic [3:0] last_hi, input logic [3:0] last_lo);
        field_t f;
        f = FIELD_IDLE;
        if ((hi == last_hi) && (lo == last_lo)) begin
            f.clr_n = 2'b00;
        end else begin
            f.inc[0] = 1'b1;
            f.inc[1] = (lo == UNIT_MAX);
        end
        return f;
    endfunction

endpackage

// File: rtl/btn_edge.sv
// Two-flop synchronizer for a raw push-button level followed by a rising-edge detector.
// rise_o is high for exactly one clk cycle per press, however long the button is held.
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    // NOTE: non-blocking assignments make every flop load its pre-edge input, so the chain shifts one stage per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/clock_ctrl.sv
// Turns the 1 Hz tick and the mode/inc buttons into per-digit inc/clr_n strobes for six BCD counters.
// Optional CLOCK_CTRL_BLINK_EN adds a blink phase that toggles per tick while a field is being set.
module clock_ctrl
    import clock_ctrl_pkg::*;
#(
    parameter logic [3:0] HR_LAST_HI = 4'd2,
    parameter logic [3:0] HR_LAST_LO = 4'd3
) (
    input  logic        CP,
    input  logic        nCLR,
    input  logic        tick_1hz,
    input  logic        btn_mode,
    input  logic        btn_inc,
    input  logic [23:0] digits,
    output logic [5:0]  inc,
    output logic [5:0]  clr_n,
    output logic [1:0]  mode,
    output logic        blink
);

    logic   mode_ev;
    logic   inc_ev;
    time_t  now;
    state_e state_q, state_d;
    field_t sec_f, min_f, hr_f;
    logic [5:0] inc_q, inc_d;
    logic [5:0] clr_n_q, clr_n_d;

    btn_edge u_mode_edge (
        .clk    (CP),
        .rst_n  (nCLR),
        .btn_i  (btn_mode),
        .rise_o (mode_ev)
    );

    btn_edge u_inc_edge (
        .clk    (CP),
        .rst_n  (nCLR),
        .btn_i  (btn_inc),
        .rise_o (inc_ev)
    );

    assign now = digits;

    // The current state picks the action; a mode event only changes which state acts next cycle.
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        sec_f   = FIELD_IDLE;
        min_f   = FIELD_IDLE;
        hr_f    = FIELD_IDLE;
        unique case (state_q)
            ST_RUN: begin
                if (tick_1hz) begin
                    sec_f = sixty_step(now.sec_hi, now.sec_lo);
                    if (sixty_wraps(now.sec_hi, now.sec_lo)) begin
                        min_f = sixty_step(now.min_hi, now.min_lo);
                        if (sixty_wraps(now.min_hi, now.min_lo)) begin
                            hr_f = hour_step(now.hr_hi, now.hr_lo, HR_LAST_HI, HR_LAST_LO);
                        end
                    end
                end
                if (mode_ev) begin
                    state_d = ST_SET_HR;
                end
            end
            ST_SET_HR: begin
                if (mode_ev) begin
                    state_d = ST_SET_MIN;
                end else if (inc_ev) begin
                    hr_f = hour_step(now.hr_hi, now.hr_lo, HR_LAST_HI, HR_LAST_LO);
                end
            end
            ST_SET_MIN: begin
                if (mode_ev) begin
                    state_d     = ST_RUN;
                    sec_f.clr_n = 2'b00;
                end else if (inc_ev) begin
                    min_f = sixty_step(now.min_hi, now.min_lo);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign inc_d[SEC_HI:SEC_LO]   = sec_f.inc;
    assign inc_d[MIN_HI:MIN_LO]   = min_f.inc;
    assign inc_d[HR_HI:HR_LO]     = hr_f.inc;
    assign clr_n_d[SEC_HI:SEC_LO] = sec_f.clr_n;
    assign clr_n_d[MIN_HI:MIN_LO] = min_f.clr_n;
    assign clr_n_d[HR_HI:HR_LO]   = hr_f.clr_n;

    always_ff @(posedge CP or negedge nCLR) begin
        if (!nCLR) begin
            state_q <= ST_RUN;
            inc_q   <= '0;
            clr_n_q <= '1;
        end else begin
            state_q <= state_d;
            inc_q   <= inc_d;
            clr_n_q <= clr_n_d;
        end
    end

    assign inc   = inc_q;
    assign clr_n = clr_n_q;
    assign mode  = state_q;

`ifdef CLOCK_CTRL_BLINK_EN
    logic blink_q, blink_d;

    always_comb begin
        blink_d = blink_q;
        if (mode_ev || (state_q == ST_RUN)) begin
            blink_d = 1'b0;
        end else if (tick_1hz) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge CP or negedge nCLR) begin
        if (!nCLR) begin
            blink_q <= 1'b0;
        end else begin
            blink_q <= blink_d;
        end
    end

    assign blink = blink_q;
`else
    assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_clock_ctrl.sv
// Random and directed stimulus for clock_ctrl, checked every cycle against a time-arithmetic reference model.
module tb_clock_ctrl;

    localparam int DAY_SECS = 24 * 3600;

    logic        CP = 1'b0;
    logic        nCLR;
    logic        tick_1hz;
    logic        btn_mode;
    logic        btn_inc;
    logic [23:0] digits;
    logic [5:0]  inc;
    logic [5:0]  clr_n;
    logic [1:0]  mode;
    logic        blink;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: 0=RUN, 1=SET_HR, 2=SET_MIN.
    int         m_state;
    logic       m_blink;
    logic [5:0] exp_inc;
    logic [5:0] exp_clr;
    logic       mode_hist[$];
    logic       inc_hist[$];

    always #5 CP = ~CP;

    clock_ctrl dut (
        .CP       (CP),
        .nCLR     (nCLR),
        .tick_1hz (tick_1hz),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .digits   (digits),
        .inc      (inc),
        .clr_n    (clr_n),
        .mode     (mode),
        .blink    (blink)
    );

    task automatic check(input string tag, input logic [23:0] act, input logic [23:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, act, exp);
        end
    endtask

    function automatic logic [23:0] to_digits(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    // A digit that moves to (old+1) mod 10 was counted; any other change needs a clear.
    function automatic void derive(input logic [23:0] old_t, input logic [23:0] new_t);
        for (int i = 0; i < 6; i++) begin
            int o;
            int n;
            o = int'((old_t >> (4 * i)) & 24'hF);
            n = int'((new_t >> (4 * i)) & 24'hF);
            if (n != o) begin
                if (n == (o + 1) % 10) exp_inc = exp_inc | 6'(1 << i);
                else                   exp_clr = exp_clr & ~6'(1 << i);
            end
        end
    endfunction

    // Button sampled high two edges ago and low three edges ago is an event at this edge.
    function automatic logic rose(input logic hist[$]);
        int n;
        n = hist.size();
        if (n < 3) return 1'b0;
        return hist[n-3] && ((n < 4) || !hist[n-4]);
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_blink = 1'b0;
        mode_hist.delete();
        inc_hist.delete();
    endfunction

    function automatic void model_edge();
        logic rm;
        logic ri;
        int   h, m, s, secs, prev;
        mode_hist.push_back(btn_mode);
        inc_hist.push_back(btn_inc);
        if (mode_hist.size() > 4) void'(mode_hist.pop_front());
        if (inc_hist.size() > 4) void'(inc_hist.pop_front());
        rm = rose(mode_hist);
        ri = rose(inc_hist);
        h = int'(digits[23:20]) * 10 + int'(digits[19:16]);
        m = int'(digits[15:12]) * 10 + int'(digits[11:8]);
        s = int'(digits[7:4]) * 10 + int'(digits[3:0]);
        exp_inc = '0;
        exp_clr = '1;
        prev = m_state;
        case (m_state)
            0: begin
                if (tick_1hz) begin
                    secs = (h * 3600 + m * 60 + s + 1) % DAY_SECS;
                    derive(digits, to_digits(secs / 3600, (secs / 60) % 60, secs % 60));
                end
                if (rm) m_state = 1;
            end
            1: begin
                if (rm)      m_state = 2;
                else if (ri) derive(digits, to_digits((h + 1) % 24, m, s));
            end
            default: begin
                if (rm) begin
                    m_state = 0;
                    exp_clr[1:0] = 2'b00;
                end else if (ri) begin
                    derive(digits, to_digits(h, (m + 1) % 60, s));
                end
            end
        endcase
`ifdef CLOCK_CTRL_BLINK_EN
        if (rm || prev == 0) m_blink = 1'b0;
        else if (tick_1hz)   m_blink = ~m_blink;
`else
        m_blink = 1'b0;
`endif
    endfunction

    task automatic cycle(input logic t, input logic bm, input logic bi, input logic [23:0] d);
        tick_1hz = t;
        btn_mode = bm;
        btn_inc  = bi;
        digits   = d;
        @(posedge CP);
        model_edge();
        #1;
        check("inc", 24'(inc), 24'(exp_inc));
        check("clr_n", 24'(clr_n), 24'(exp_clr));
        check("mode", 24'(mode), 24'(m_state));
        check("blink", 24'(blink), 24'(m_blink));
    endtask

    task automatic idle(input int n, input logic [23:0] d);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, d);
    endtask

    // One press of either button; optional tick lands on the edge that sees the press event.
    task automatic press(input logic on_mode, input logic [23:0] d, input logic with_tick);
        for (int i = 0; i < 5; i++) cycle(with_tick && (i == 2), on_mode, !on_mode, d);
        idle(4, d);
    endtask

    task automatic do_reset();
        nCLR     = 1'b0;
        tick_1hz = 1'b0;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        digits   = '0;
        repeat (3) @(posedge CP);
        @(negedge CP);
        nCLR = 1'b1;
        model_reset();
        #1;
        check("rst_inc", 24'(inc), 24'h0);
        check("rst_clr_n", 24'(clr_n), 24'h3F);
        check("rst_mode", 24'(mode), 24'h0);
        check("rst_blink", 24'(blink), 24'h0);
    endtask

    initial begin
        logic       bm, bi, t;
        int         since;
        int         h, m, s;

        do_reset();

        // Run-mode carry chain at the interesting boundaries.
        cycle(1'b1, 1'b0, 1'b0, to_digits(0, 0, 0));
        idle(2, to_digits(0, 0, 1));
        cycle(1'b1, 1'b0, 1'b0, to_digits(0, 0, 59));
        idle(2, to_digits(0, 1, 0));
        cycle(1'b1, 1'b0, 1'b0, to_digits(23, 59, 59));
        idle(2, to_digits(0, 0, 0));
        cycle(1'b1, 1'b0, 1'b0, to_digits(9, 59, 59));
        idle(2, to_digits(10, 0, 0));
        cycle(1'b1, 1'b0, 1'b0, to_digits(12, 34, 9));
        idle(2, to_digits(12, 34, 10));

        // An inc press in RUN is ignored.
        press(1'b0, to_digits(12, 34, 10), 1'b0);

        // Enter SET_HR with a coincident tick, then step the hour through the wrap.
        press(1'b1, to_digits(22, 30, 15), 1'b1);
        press(1'b0, to_digits(22, 30, 15), 1'b1);
        press(1'b0, to_digits(22, 30, 15), 1'b0);
        press(1'b0, to_digits(23, 30, 15), 1'b1);
        press(1'b0, to_digits(19, 30, 15), 1'b0);

        // SET_MIN: ticks only move blink; minute wraps without touching hours.
        press(1'b1, to_digits(20, 30, 15), 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0, to_digits(20, 30, 15));
            idle(3, to_digits(20, 30, 15));
        end
        press(1'b0, to_digits(20, 59, 15), 1'b0);
        press(1'b0, to_digits(20, 39, 15), 1'b0);

        // Mode and inc together: inc dropped, return to RUN clears the seconds.
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1, to_digits(20, 40, 15));
        idle(4, to_digits(20, 40, 0));

        // Reset asserted while a strobe is on the outputs.
        cycle(1'b1, 1'b0, 1'b0, to_digits(23, 59, 59));
        nCLR = 1'b0;
        #1;
        check("midrst_inc", 24'(inc), 24'h0);
        check("midrst_clr_n", 24'(clr_n), 24'h3F);
        do_reset();

        // Random traffic with near-carry bias.
        bm = 1'b0;
        bi = 1'b0;
        since = 3;
        for (int i = 0; i < 3000; i++) begin
            t = (since >= 3) && ($urandom_range(3) == 0);
            since = t ? 0 : since + 1;
            if ($urandom_range(5) == 0) bm = ~bm;
            if ($urandom_range(4) == 0) bi = ~bi;
            case ($urandom_range(4))
                0:       h = 23;
                1:       h = 9;
                2:       h = 19;
                default: h = int'($urandom_range(23));
            endcase
            m = ($urandom_range(2) == 0) ? 59 : int'($urandom_range(59));
            s = ($urandom_range(1) == 0) ? 59 : int'($urandom_range(59));
            cycle(t, bm, bi, to_digits(h, m, s));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/clock_ctrl.md
# clock_ctrl

Sequencing controller for the digital clock's six cascaded BCD digit counters (seconds, minutes and hours, each split into units and tens). It turns the 1 Hz tick into per-digit increment and clear strobes, which implements the 60/60/24 carry chain on top of plain mod-10 counters. It also runs the user time-set mode FSM from two push-buttons. It sits between the tick divider and the digit counters, and feeds the display blink logic.

## Interface
Parameters:
- HR_LAST_HI, 2, tens digit of the last hour before wrap
- HR_LAST_LO, 3, units digit of the last hour before wrap (default 23 → 00)

Ports:
- CP  input  1  system clock, rising edge
- nCLR  input  1  asynchronous active-low reset
- tick_1hz  input  1  one-CP-cycle pulse, once per second
- btn_mode  input  1  raw mode button level, asynchronous
- btn_inc  input  1  raw increment button level, asynchronous
- digits  input  24  current counter values {hr_hi,hr_lo,min_hi,min_lo,sec_hi,sec_lo}, 4-bit BCD each
- inc  output  6  per-digit count-enable strobe, bit0=sec_lo … bit5=hr_hi
- clr_n  output  6  per-digit active-low clear pulse, same bit order
- mode  output  2  0=RUN, 1=SET_HR, 2=SET_MIN
- blink  output  1  display blink phase for the field being set

## Operation
- Reset:
  - Clock and reset are fixed as one clock, CP, with reset nCLR asynchronous and active-low.
  - Reset values: state RUN, inc=0, clr_n=6'b111111, mode=0, blink=0, button sync/edge registers 0.
- Buttons:
  - Each button passes through a 2-flop synchronizer and a rising-edge detector.
  - One press produces one event; held buttons produce no repeats.
- FSM: RUN → SET_HR → SET_MIN → RUN, advancing on each mode event.
  - On SET_MIN → RUN: pulse clr_n[1:0] low, which zeroes the seconds.
- RUN, on tick_1hz:
  - inc[0] is always set.
  - If sec_lo==9: seconds carry. Set inc[1] if sec_hi<5; otherwise pulse clr_n[1] and propagate the carry to min_lo.
  - Minutes use the same rule (units mod 10, tens mod 6), carrying into hours.
  - Hour carry, when hr==HR_LAST_HI:HR_LAST_LO: pulse clr_n[5:4] and do not set inc[4].
  - Hour carry otherwise: set inc[4]; if hr_lo==9, also set inc[5].
  - Result: 23:59:59 → 00:00:00.
- SET_HR:
  - Ticks produce no strobes.
  - An inc event advances the hour with the same wrap rule.
  - No carry to or from minutes.
- SET_MIN:
  - Ticks produce no strobes.
  - An inc event advances the minute with 59 → 00 wrap.
  - No carry to hours.
- Simultaneous events:
  - The current state decides the action and the mode transition takes effect after it. A tick coincident with RUN→SET_HR is applied.
  - An inc event coincident with a mode event is dropped.
- An inc event in RUN is ignored.
- A digit within a field never receives inc and clr_n in the same cycle.

## Timing
- All outputs are registered.
- Strobe latency:
  - Tick: strobes appear in cycle N+1 when the tick is sampled at cycle N.
  - Button: strobes appear 3 cycles after the first CP edge that samples the button high (2 sync + 1 edge/out).
- Each strobe and clear pulse lasts exactly one CP cycle.
- Counters update on the edge that ends an inc strobe. A clr_n pulse clears the counter asynchronously during the low cycle.
- The digits input is sampled in the same cycle as the event.
- Requirement on the source: tick_1hz pulses must be ≥3 cycles apart so that digits reflect the previous update.
- Reset asserted mid-strobe forces inc=0 and clr_n=all ones immediately.

## Configuration
- CLOCK_CTRL_BLINK_EN defined:
  - In SET_HR/SET_MIN, blink toggles on every tick_1hz.
  - blink is forced to 0 in RUN and on every mode change.
- Undefined: blink is tied to 0 and its register is removed.

## Structure
- Shared package clock_ctrl_pkg holds:
  - state enum (RUN, SET_HR, SET_MIN)
  - digit index constants (SEC_LO … HR_HI)
  - BCD limits (UNIT_MAX=9, TENS60_MAX=5)
- Sub-module btn_edge: 2-flop synchronizer plus rising-edge detector, instantiated once per button.

## Test plan
- Reset with digits=0, then one tick → next cycle inc=6'b000001, clr_n=6'b111111, mode=0.
- digits=00:00:59, tick → inc[0]=1, inc[2]=1, clr_n[1]=0, all other bits idle.
- digits=23:59:59, tick → inc[0], clr_n[1], clr_n[3], clr_n[5:4] low; inc[4]=0.
- Mode press, then 3 inc presses with hr=22 → mode=1; inc[4] strobes on the first two presses; third press, at hr=23, gives clr_n[5:4] low; no strobes from ticks.
- Two mode presses from SET_HR → mode 2, then 0; clr_n[1:0] low one cycle on the return to RUN.
- With CLOCK_CTRL_BLINK_EN: in SET_MIN, four ticks → blink 1,0,1,0; mode press → blink=0.
